fp_normalize_pack: RTL and testbench

// - Post-ALU stage of the FP32 adder: consumes the raw mantissa sum/difference and carry from the

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_round_rne.sv | 21 ++
 rtl/fp_normalize_pack.sv | 179 +++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the adder back end: field widths, special encodings,
// normalizer state encoding and the word packing helper.
package fp_pkg;

  localparam int         FP_EXP_W  = 8;
  localparam int         FP_FRAC_W = 23;
  localparam int         FP_BIAS   = 127;
  localparam logic [7:0] EXP_INF   = 8'hFF;
  localparam int         MAX_SHIFT = 23;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ROUND = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  function automatic logic [31:0] pack_fp(input logic                 sign,
                                          input logic [FP_EXP_W-1:0]  exp,
                                          input logic [FP_FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment on a normalized mantissa using guard/round/sticky.
// A carry out of the top means the result wrapped to 1.000..; mant_rnd is then the renormalized value.
module fp_round_rne #(
  parameter int MAN_W = 24
) (
  input  logic [MAN_W-1:0] mant,
  input  logic [2:0]       grs,
  output logic [MAN_W-1:0] mant_rnd,
  output logic             mant_carry
);

  logic           up;
  logic [MAN_W:0] sum;

  // Ties (G=1, R=S=0) only round up when that makes the LSB even.
  assign up         = grs[2] & (grs[1] | grs[0] | mant[0]);
  assign sum        = {1'b0, mant} + {{MAN_W{1'b0}}, up};
  assign mant_carry = sum[MAN_W];
  assign mant_rnd   = mant_carry ? {1'b1, {(MAN_W-1){1'b0}}} : sum[MAN_W-1:0];

endmodule

// File: rtl/fp_normalize_pack.sv
// FP32 adder post-ALU stage: iterative normalizer (one left shift per cycle), RNE rounding
// and IEEE-754 packing, with a single item in flight between valid/ready handshakes.
module fp_normalize_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_mant,
  input  logic             in_carry,
  input  logic [2:0]       in_grs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_zero
);

  localparam int EW = EXP_W + 2;
  typedef logic signed [EW-1:0] sexp_t;

  // Two extra exponent bits keep overflow/underflow visible instead of wrapping.
  localparam sexp_t EXP_MAX  = sexp_t'(2*BIAS + 1);
  localparam sexp_t EXP_ZERO = sexp_t'(0);

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  sexp_t            exp_q, exp_d;
  logic [MAN_W-1:0] mant_q, mant_d;
  logic             carry_q, carry_d;
  logic [2:0]       grs_q, grs_d;
  logic [4:0]       shcnt_q, shcnt_d;
  logic [31:0]      res_q, res_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

  logic [MAN_W-1:0] mant_shl, mant_rnd;
  logic [2:0]       grs_shl;
  sexp_t            exp_dec, exp_rnd;
  logic             rnd_carry;

  assign mant_shl = {mant_q[MAN_W-2:0], grs_q[2]};
  assign grs_shl  = {grs_q[1:0], 1'b0};
  assign exp_dec  = exp_q - sexp_t'(1);
  assign exp_rnd  = exp_q + sexp_t'(rnd_carry);

  fp_round_rne #(.MAN_W(MAN_W)) u_rnd (
    .mant       (mant_q),
    .grs        (grs_q),
    .mant_rnd   (mant_rnd),
    .mant_carry (rnd_carry)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    carry_d = carry_q;
    grs_d   = grs_q;
    shcnt_d = shcnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = sexp_t'({2'b00, in_exp});
          mant_d  = in_mant;
          carry_d = in_carry;
          grs_d   = in_grs;
          shcnt_d = '0;
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (carry_q) begin
          // Sum overflowed into the carry: one right shift, sticky absorbs what falls off.
          mant_d  = {carry_q, mant_q[MAN_W-1:1]};
          grs_d   = {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
          exp_d   = exp_q + sexp_t'(1);
          carry_d = 1'b0;
          state_d = ST_ROUND;
        end else if (mant_q == '0 && grs_q == '0) begin
          res_d   = pack_fp(1'b0, 8'h00, 23'h0);
          zero_d  = 1'b1;
          state_d = ST_OUT;
        end else if (mant_q[MAN_W-1]) begin
          state_d = ST_ROUND;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        mant_d  = mant_shl;
        grs_d   = grs_shl;
        exp_d   = exp_dec;
        shcnt_d = shcnt_q + 5'd1;
        if (exp_dec <= EXP_ZERO ||
            (!mant_shl[MAN_W-1] && shcnt_q == 5'(MAX_SHIFT - 1))) begin
          res_d   = pack_fp(sign_q, 8'h00, 23'h0);
          unf_d   = 1'b1;
          zero_d  = 1'b1;
          state_d = ST_OUT;
        end else if (mant_shl[MAN_W-1]) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        mant_d  = mant_rnd;
        exp_d   = exp_rnd;
        state_d = ST_OUT;
        if (exp_rnd >= EXP_MAX) begin
          res_d = pack_fp(sign_q, EXP_INF, 23'h0);
          ovf_d = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          res_d  = pack_fp(sign_q, 8'h00, 23'h0);
          unf_d  = 1'b1;
          zero_d = 1'b1;
        end else begin
          res_d = pack_fp(sign_q, exp_rnd[EXP_W-1:0], mant_rnd[MAN_W-2:0]);
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      carry_q <= 1'b0;
      grs_q   <= '0;
      shcnt_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      carry_q <= carry_d;
      grs_q   <= grs_d;
      shcnt_q <= shcnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_OUT);
  assign out_result = res_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed and randomized checks of fp_normalize_pack against an arithmetic reference model.
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_carry;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic [2:0]  in_grs;
  logic        out_valid, out_ready, out_ovf, out_unf, out_zero;
  logic [31:0] out_result;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] obs_res;
  logic        obs_ovf, obs_unf, obs_zero;
  int          obs_lat;

  fp_normalize_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_carry   (in_carry),
    .in_grs     (in_grs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value = {carry, mant, g, r, s} as plain integers; normalize, round, pack.
  function automatic void model(input bit s, input int e_in, input int m_in, input bit c,
                                input int grs_in, output logic [31:0] res, output bit ovf,
                                output bit unf, output bit zro, output int lat);
    int e, n, m, v;
    bit g, r, st;
    ovf = 0; unf = 0; zro = 0; res = '0; lat = 0;
    if (!c && m_in == 0 && grs_in == 0) begin
      zro = 1; lat = 2;
      return;
    end
    e = e_in; n = 0;
    if (c) begin
      m  = (m_in >> 1) | (1 << 23);
      g  = (m_in & 1) != 0;
      r  = (grs_in & 4) != 0;
      st = (grs_in & 3) != 0;
      e  = e + 1;
    end else begin
      v = (m_in << 3) | grs_in;
      while ((v & (1 << 26)) == 0) begin
        v = (v << 1) & 'h7FFFFFF;
        e = e - 1;
        n = n + 1;
        if (e <= 0 || ((v & (1 << 26)) == 0 && n >= 23)) begin
          res = {s, 31'b0}; unf = 1; zro = 1; lat = 2 + n;
          return;
        end
      end
      m  = v >> 3;
      g  = (v & 4) != 0;
      r  = (v & 2) != 0;
      st = (v & 1) != 0;
    end
    lat = 3 + n;
    if (g && (r || st || (m & 1) != 0)) m = m + 1;
    if (m == (1 << 24)) begin
      m = 1 << 23;
      e = e + 1;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'h0}; ovf = 1;
    end else if (e <= 0) begin
      res = {s, 31'b0}; unf = 1; zro = 1;
    end else begin
      res = {s, 8'(e), 23'(m)};
    end
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge where out_valid is first seen.
  task automatic drive(input bit s, input logic [7:0] e, input logic [23:0] m, input bit c,
                       input logic [2:0] g);
    in_sign = s; in_exp = e; in_mant = m; in_carry = c; in_grs = g;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    obs_lat = 1;
    while (!out_valid && obs_lat < 80) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_res = out_result; obs_ovf = out_ovf; obs_unf = out_unf; obs_zero = out_zero;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string tag, input logic [31:0] r, input bit o, input bit u,
                          input bit z, input int l);
    chk({tag, ".res"},  obs_res, r);
    chk({tag, ".ovf"},  32'(obs_ovf), 32'(o));
    chk({tag, ".unf"},  32'(obs_unf), 32'(u));
    chk({tag, ".zero"}, 32'(obs_zero), 32'(z));
    chk({tag, ".lat"},  32'(obs_lat), 32'(l));
  endtask

  initial begin
    logic [31:0] m_res;
    bit          m_ovf, m_unf, m_zro;
    int          m_lat;
    bit          s_r, c_r;
    logic [7:0]  e_r;
    logic [23:0] mt_r;
    logic [2:0]  g_r;
    int          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 0; in_exp = 0; in_mant = 0; in_carry = 0; in_grs = 0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready",  32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result",    out_result, 32'h0);
    chk("rst.flags",     32'({out_ovf, out_unf, out_zero}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    drive(0, 8'd127, 24'h000000, 1, 3'b000); check_op("one_plus_one", 32'h40000000, 0, 0, 0, 3); retire();
    drive(0, 8'd127, 24'h400000, 0, 3'b000); check_op("1p5_minus_1", 32'h3F000000, 0, 0, 0, 4); retire();
    drive(1, 8'd127, 24'h000000, 0, 3'b000); check_op("exact_cancel", 32'h00000000, 0, 0, 1, 2); retire();
    drive(0, 8'd254, 24'h800000, 1, 3'b000); check_op("overflow", 32'h7F800000, 1, 0, 0, 3); retire();
    drive(0, 8'd126, 24'hFFFFFF, 0, 3'b100); check_op("round_carry", 32'h3F800000, 0, 0, 0, 3); retire();
    drive(0, 8'd127, 24'h800000, 0, 3'b100); check_op("tie_even_keep", 32'h3F800000, 0, 0, 0, 3); retire();
    drive(0, 8'd127, 24'h800001, 0, 3'b100); check_op("tie_odd_up", 32'h3F800002, 0, 0, 0, 3); retire();
    drive(1, 8'd3,   24'h000100, 0, 3'b000); check_op("underflow", 32'h80000000, 0, 1, 1, 5); retire();

    out_ready = 1'b0;
    drive(0, 8'd127, 24'h000000, 1, 3'b000);
    chk("bp.lat", 32'(obs_lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_result", out_result, 32'h40000000);
      chk("bp.in_ready",    32'(in_ready), 32'd0);
      chk("bp.out_valid",   32'(out_valid), 32'd1);
    end
    retire();
    chk("bp.released", 32'(out_valid), 32'd0);

    in_sign = 0; in_exp = 8'd100; in_mant = 24'h000100; in_carry = 0; in_grs = 0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready",  32'(in_ready), 32'd1);
    chk("rst_mid.result",    out_result, 32'h0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mid.no_emit", 32'(seen), 32'd0);

    for (int i = 0; i < 300; i++) begin
      s_r = 1'($urandom);
      c_r = 1'($urandom);
      g_r = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       e_r = 8'($urandom_range(1, 6));
        1:       e_r = 8'($urandom_range(248, 254));
        default: e_r = 8'($urandom_range(1, 254));
      endcase
      mt_r = 24'($urandom) >> $urandom_range(0, 23);
      if (!c_r && mt_r == 0) mt_r = 24'd1;
      if ($urandom_range(0, 19) == 0) begin
        c_r = 0; mt_r = 0; g_r = 0;
      end
      model(s_r, int'(e_r), int'(mt_r), c_r, int'(g_r), m_res, m_ovf, m_unf, m_zro, m_lat);
      drive(s_r, e_r, mt_r, c_r, g_r);
      check_op($sformatf("rand%0d", i), m_res, m_ovf, m_unf, m_zro, m_lat);
      retire();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
